sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Sequencer and two-port arbiter for the external 1M×16 async SRAM that holds the sprite and tile sheets. It shares the chip between two requesters:
- the pixel-fetch renderer, which computes sprite addresses per pixel and must sustain one read every two Clk;
- the sprite loader fed by the NIOS, which reads and writes.

The block generates all SRAM strobes and is the only driver of them. The top level instantiates the SRAM_DQ tristate from `sram_dq_out` / `sram_dq_oe`.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- STARVE_LIMIT, 8, consecutive pixel grants allowed while the loader waits (1..255)

- Clk  in  1  system clock (CLOCK_50)
- Reset_n  in  1  asynchronous, active-low reset
- pix_req  in  1  pixel read request; held with pix_addr until pix_ack
- pix_addr  in  ADDR_W  pixel read address
- pix_ack  out  1  one-cycle pulse: request accepted
- pix_rvalid  out  1  one-cycle pulse: pix_rdata valid
- pix_rdata  out  DATA_W  captured read data
- ldr_req  in  1  loader request; held with ldr_we, ldr_addr and ldr_wdata until ldr_ack
- ldr_we  in  1  1 = write, 0 = read
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_ack  out  1  one-cycle pulse: request accepted
- ldr_rvalid  out  1  one-cycle pulse: ldr_rdata valid (reads only)
- ldr_rdata  out  DATA_W  captured read data
- SRAM_ADDR  out  ADDR_W  registered address
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low strobes
- sram_dq_out  out  DATA_W  write data to pad
- sram_dq_oe  out  1  pad drive enable
- sram_dq_in  in  DATA_W  pad read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RD1, RD2, WR1, WR2, WR3.
- Decision points are IDLE, RD2 and WR3. At each decision point, arbitrate and branch to RD1, WR1 or IDLE.
- Arbitration:
  - grant pix if pix_req && (!ldr_req || starve_cnt < STARVE_LIMIT);
  - else grant ldr if ldr_req;
  - else go to IDLE.
- starve_cnt:
  - increments, saturating, on each pix grant while ldr_req = 1;
  - clears on any ldr grant;
  - clears in any cycle with ldr_req = 0.
- A grant pulses the winner's ack in the first cycle of the next state (RD1 or WR1).
- RD1: SRAM_ADDR driven, CE_N = OE_N = UB_N = LB_N = 0, WE_N = 1.
- RD2: same strobes. sram_dq_in is registered into the owner's rdata at the end of RD2. The owner's rvalid pulses in the following cycle.
- WR1: address setup only. CE_N/UB_N/LB_N = 0, OE_N = 1, WE_N = 1, sram_dq_oe = 0. This gives bus turnaround after a read.
- WR2: WE_N = 0, sram_dq_oe = 1, sram_dq_out = latched ldr_wdata.
- WR3: WE_N = 1, sram_dq_oe = 1, data and address held (hold after WE rising).
- Address and write data are latched at grant. Requester inputs are don't-care after ack.
- A request withdrawn before its ack is never issued.
- In IDLE: CE_N = OE_N = WE_N = UB_N = LB_N = 1, sram_dq_oe = 0. SRAM_ADDR holds its last value.
- rdata holds its value until the next read by the same port.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Reset values: state IDLE, starve_cnt 0, all SRAM strobes 1, sram_dq_oe 0, SRAM_ADDR 0, sram_dq_out 0, acks 0, rvalids 0, rdata 0, busy 0.
- Reset_n low forces WE_N = 1 and sram_dq_oe = 0 immediately (asynchronously). This holds even mid-write; the partial write is abandoned.
- Read latency: req sampled in cycle t (IDLE), ack at t+1, data captured end of t+2, rvalid at t+3.
- Back-to-back reads: RD2 → RD1 gives one read per 2 cycles. The pixel port sustains this indefinitely while the loader is idle.
- Write occupancy: 3 cycles. Any transition from WR3 to RD1 is legal with no gap.
- With both ports requesting continuously: STARVE_LIMIT pixel reads, then one loader access, repeating.
- Simultaneous requests at starve_cnt < STARVE_LIMIT: pix wins.

## Structure
- Shared package sram_arb_pkg holds:
  - state enum typedef (IDLE, RD1, RD2, WR1, WR2, WR3);
  - default ADDR_W and DATA_W;
  - owner enum (OWN_PIX, OWN_LDR), used to route rvalid/rdata.
- Single module, no sub-module. The starvation counter and strobe registers are small enough to stay inline.
- The tristate buffer stays at the top level: SRAM_DQ = sram_dq_oe ? sram_dq_out : 'z.

## Test plan
- Reset: hold Reset_n = 0 mid-WR2 → WE_N = 1 and sram_dq_oe = 0 within the same cycle. After release, all outputs are at reset values and state is IDLE.
- Single pixel read:
  - Stimulus: pix_req with pix_addr = 0x00410; the SRAM model returns 0x0007.
  - Required: pix_ack at t+1, SRAM_ADDR = 0x00410 with OE_N low for 2 cycles, pix_rvalid at t+3 with pix_rdata = 0x0007.
- Streaming: pix_req held for 64 consecutive addresses, loader idle → 64 rvalid pulses spaced exactly 2 cycles apart, in address order.
- Write then read-back:
  - Stimulus: loader write 0xBEEF to 0x12345, then loader read of 0x12345.
  - Required: WE_N low exactly 1 cycle, with sram_dq_oe high only in WR2 and WR3. The read returns 0xBEEF on ldr_rdata.
- Starvation: both requests held continuously with STARVE_LIMIT = 8 → 8 pix_ack pulses, then 1 ldr_ack, repeating. Neither port waits unboundedly.
- Withdrawal: ldr_req raised for 1 cycle while a pixel read is in RD1 and dropped before a decision point → no ldr_ack and no SRAM write cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the sprite/tile SRAM arbiter: FSM states, read owner,
// default bus widths and the strobe pattern driven in each state.
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        WR3  = 3'd5
    } state_t;

    // Which port the access in flight belongs to; steers rvalid/rdata.
    typedef enum logic {
        OWN_PIX = 1'b0,
        OWN_LDR = 1'b1
    } owner_t;

    // Active-low SRAM strobes plus the pad drive enable, as one register.
    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
        logic dq_oe;
    } strobe_t;

    // Strobe pattern to present while the FSM sits in state s.
    function automatic strobe_t strobes_for(state_t s);
        strobe_t st;
        st = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};
        case (s)
            RD1, RD2: st = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0, dq_oe: 1'b0};
            // Address setup with OE high: turnaround after a read.
            WR1:      st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0, dq_oe: 1'b0};
            WR2:      st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, ub_n: 1'b0, lb_n: 1'b0, dq_oe: 1'b1};
            // WE back high, data and address still driven for hold time.
            WR3:      st = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b0, lb_n: 1'b0, dq_oe: 1'b1};
            default:  st = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0};
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes and SRAM pin bundle for the sprite/tile SRAM arbiter.
//
// Handshake: a requester raises *_req with its address (and, for the loader,
// we/wdata) and holds them stable until *_ack pulses for one cycle; the
// arbiter latches everything at grant, so the inputs are don't-care from the
// ack cycle onward. Dropping *_req before ack withdraws the request. Read
// data arrives later as a one-cycle *_rvalid pulse with *_rdata, which then
// holds until the next read on that port.
interface sram_arbiter_if #(
    parameter int ADDR_W = sram_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = sram_arb_pkg::DEF_DATA_W
);
    // Pixel-fetch renderer (read only)
    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_ack;
    logic              pix_rvalid;
    logic [DATA_W-1:0] pix_rdata;

    // Sprite loader (read/write)
    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;

    // SRAM pins (DQ tristate lives above this block)
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;

    // Arbiter side
    modport slave (
        input  pix_req, pix_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, sram_dq_in,
        output pix_ack, pix_rvalid, pix_rdata, ldr_ack, ldr_rvalid, ldr_rdata,
        output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        output sram_dq_out, sram_dq_oe
    );

    // Requesters and SRAM pad side
    modport master (
        output pix_req, pix_addr, ldr_req, ldr_we, ldr_addr, ldr_wdata, sram_dq_in,
        input  pix_ack, pix_rvalid, pix_rdata, ldr_ack, ldr_rvalid, ldr_rdata,
        input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        input  sram_dq_out, sram_dq_oe
    );

endinterface

// File: rtl/sram_arbiter.sv
// Sequencer and two-port arbiter for the 1Mx16 async sprite/tile SRAM.
// Pixel reads take 2 cycles, loader writes 3; arbitration happens in IDLE,
// RD2 and WR3 so back-to-back accesses have no gap. Every output, including
// the strobes, comes straight from a flop reset asynchronously, so a reset
// mid-write drops WE_N and the pad enable at once.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    sram_arbiter_if.slave  bus,
    output logic           busy,
    output state_t         state_dbg
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t            state;
    owner_t            owner;
    strobe_t           stb;
    logic [7:0]        starve_cnt;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] dq_out_q;
    logic              pix_ack_q;
    logic              ldr_ack_q;
    logic              pix_rvalid_q;
    logic              ldr_rvalid_q;
    logic [DATA_W-1:0] pix_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;

    logic at_decision;
    logic pix_win;
    logic ldr_win;

    // Arbitration: pixel port has priority until the loader has watched
    // LIMIT pixel grants go by, then the loader gets exactly one turn.
    always_comb begin
        at_decision = (state == IDLE) || (state == RD2) || (state == WR3);
        pix_win     = bus.pix_req && (!bus.ldr_req || (starve_cnt < LIMIT));
        ldr_win     = bus.ldr_req && !pix_win;
    end

    // Main sequencer: state, strobes, address/data latches, acks and rdata.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            owner        <= OWN_PIX;
            stb          <= strobes_for(IDLE);
            starve_cnt   <= 8'd0;
            sram_addr_q  <= '0;
            dq_out_q     <= '0;
            pix_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            pix_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
            pix_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
            busy         <= 1'b0;
        end else begin
            pix_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            pix_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;

            // Data has been on the bus for two cycles; capture for the owner.
            if (state == RD2) begin
                if (owner == OWN_PIX) begin
                    pix_rdata_q  <= bus.sram_dq_in;
                    pix_rvalid_q <= 1'b1;
                end else begin
                    ldr_rdata_q  <= bus.sram_dq_in;
                    ldr_rvalid_q <= 1'b1;
                end
            end

            // A pix grant with ldr_req high only happens while the count is
            // below LIMIT, so the increment saturates at LIMIT by itself.
            if (!bus.ldr_req) begin
                starve_cnt <= 8'd0;
            end else if (at_decision && ldr_win) begin
                starve_cnt <= 8'd0;
            end else if (at_decision && pix_win) begin
                starve_cnt <= starve_cnt + 8'd1;
            end

            case (state)
                RD1: begin
                    state <= RD2;
                    stb   <= strobes_for(RD2);
                    busy  <= 1'b1;
                end
                WR1: begin
                    state <= WR2;
                    stb   <= strobes_for(WR2);
                    busy  <= 1'b1;
                end
                WR2: begin
                    state <= WR3;
                    stb   <= strobes_for(WR3);
                    busy  <= 1'b1;
                end
                IDLE, RD2, WR3: begin
                    if (pix_win) begin
                        state       <= RD1;
                        stb         <= strobes_for(RD1);
                        owner       <= OWN_PIX;
                        sram_addr_q <= bus.pix_addr;
                        pix_ack_q   <= 1'b1;
                        busy        <= 1'b1;
                    end else if (ldr_win) begin
                        state       <= bus.ldr_we ? WR1 : RD1;
                        stb         <= strobes_for(bus.ldr_we ? WR1 : RD1);
                        owner       <= OWN_LDR;
                        sram_addr_q <= bus.ldr_addr;
                        ldr_ack_q   <= 1'b1;
                        busy        <= 1'b1;
                        if (bus.ldr_we) begin
                            dq_out_q <= bus.ldr_wdata;
                        end
                    end else begin
                        // Address deliberately held; only strobes go idle.
                        state <= IDLE;
                        stb   <= strobes_for(IDLE);
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    stb   <= strobes_for(IDLE);
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg       = state;

    assign bus.pix_ack     = pix_ack_q;
    assign bus.pix_rvalid  = pix_rvalid_q;
    assign bus.pix_rdata   = pix_rdata_q;
    assign bus.ldr_ack     = ldr_ack_q;
    assign bus.ldr_rvalid  = ldr_rvalid_q;
    assign bus.ldr_rdata   = ldr_rdata_q;

    assign bus.SRAM_ADDR   = sram_addr_q;
    assign bus.SRAM_CE_N   = stb.ce_n;
    assign bus.SRAM_OE_N   = stb.oe_n;
    assign bus.SRAM_WE_N   = stb.we_n;
    assign bus.SRAM_UB_N   = stb.ub_n;
    assign bus.SRAM_LB_N   = stb.lb_n;
    assign bus.sram_dq_oe  = stb.dq_oe;
    assign bus.sram_dq_out = dq_out_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset values, single pixel read, pixel
// streaming, loader write + read-back, starvation pattern, request
// withdrawal and reset in the middle of a write. Inputs are driven and
// outputs sampled on the falling edge.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 8;

    logic   Clk = 1'b0;
    logic   Reset_n;
    logic   busy;
    state_t state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .bus      (bus.slave),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- SRAM model (4K words, address aliased) ----------------
    logic [15:0] mem [0:4095];

    assign bus.sram_dq_in = (!bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N)
                          ? mem[bus.SRAM_ADDR[11:0]] : 16'h0000;

    always @(posedge Clk) begin
        if (Reset_n && !bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.sram_dq_oe)
            mem[bus.SRAM_ADDR[11:0]] <= bus.sram_dq_out;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ce_n"},       32'(bus.SRAM_CE_N), 32'd1);
        check({pfx, "_oe_n"},       32'(bus.SRAM_OE_N), 32'd1);
        check({pfx, "_we_n"},       32'(bus.SRAM_WE_N), 32'd1);
        check({pfx, "_ub_n"},       32'(bus.SRAM_UB_N), 32'd1);
        check({pfx, "_lb_n"},       32'(bus.SRAM_LB_N), 32'd1);
        check({pfx, "_dq_oe"},      32'(bus.sram_dq_oe), 32'd0);
        check({pfx, "_addr"},       32'(bus.SRAM_ADDR), 32'd0);
        check({pfx, "_dq_out"},     32'(bus.sram_dq_out), 32'd0);
        check({pfx, "_pix_ack"},    32'(bus.pix_ack), 32'd0);
        check({pfx, "_ldr_ack"},    32'(bus.ldr_ack), 32'd0);
        check({pfx, "_pix_rvalid"}, 32'(bus.pix_rvalid), 32'd0);
        check({pfx, "_ldr_rvalid"}, 32'(bus.ldr_rvalid), 32'd0);
        check({pfx, "_pix_rdata"},  32'(bus.pix_rdata), 32'd0);
        check({pfx, "_ldr_rdata"},  32'(bus.ldr_rdata), 32'd0);
        check({pfx, "_busy"},       32'(busy), 32'd0);
        check({pfx, "_state"},      32'(state_dbg), 32'(IDLE));
    endtask

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        bus.pix_req   = 1'b0;
        bus.pix_addr  = '0;
        bus.ldr_req   = 1'b0;
        bus.ldr_we    = 1'b0;
        bus.ldr_addr  = '0;
        bus.ldr_wdata = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int  acks;
        int  rvs;
        int  last_rv;
        int  g;
        int  n_ldr_ack;
        int  n_we_low;
        int  n_oe;
        bit  seen;

        for (int i = 0; i < 4096; i++) mem[i] <= 16'(i) ^ 16'h5A5A;
        mem[12'h410] <= 16'h0007;

        Reset_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        Reset_n = 1'b1;
        tick();
        check_reset_values("rst");

        // ---- single pixel read ----
        bus.pix_req  = 1'b1;
        bus.pix_addr = 20'h00410;
        tick();                                   // RD1
        check("rd_ack",      32'(bus.pix_ack), 32'd1);
        check("rd1_addr",    32'(bus.SRAM_ADDR), 32'h00410);
        check("rd1_oe_n",    32'(bus.SRAM_OE_N), 32'd0);
        check("rd1_we_n",    32'(bus.SRAM_WE_N), 32'd1);
        bus.pix_req  = 1'b0;
        bus.pix_addr = 20'h00000;
        tick();                                   // RD2
        check("rd2_ack_gone", 32'(bus.pix_ack), 32'd0);
        check("rd2_oe_n",    32'(bus.SRAM_OE_N), 32'd0);
        check("rd2_addr",    32'(bus.SRAM_ADDR), 32'h00410);
        check("rd2_rvalid",  32'(bus.pix_rvalid), 32'd0);
        tick();                                   // IDLE, rvalid
        check("rd_rvalid",   32'(bus.pix_rvalid), 32'd1);
        check("rd_rdata",    32'(bus.pix_rdata), 32'h0007);
        check("rd_idle_oe_n", 32'(bus.SRAM_OE_N), 32'd1);
        check("rd_idle_busy", 32'(busy), 32'd0);
        check("rd_addr_hold", 32'(bus.SRAM_ADDR), 32'h00410);
        tick();
        check("rd_rvalid_pulse", 32'(bus.pix_rvalid), 32'd0);

        // ---- loader write 0xBEEF to 0x12345 ----
        bus.ldr_req   = 1'b1;
        bus.ldr_we    = 1'b1;
        bus.ldr_addr  = 20'h12345;
        bus.ldr_wdata = 16'hBEEF;
        tick();                                   // WR1
        check("wr1_ack",   32'(bus.ldr_ack), 32'd1);
        check("wr1_state", 32'(state_dbg), 32'(WR1));
        check("wr1_addr",  32'(bus.SRAM_ADDR), 32'h12345);
        check("wr1_ce_n",  32'(bus.SRAM_CE_N), 32'd0);
        check("wr1_oe_n",  32'(bus.SRAM_OE_N), 32'd1);
        check("wr1_we_n",  32'(bus.SRAM_WE_N), 32'd1);
        check("wr1_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        idle_inputs();                            // inputs are don't-care now
        tick();                                   // WR2
        check("wr2_we_n",   32'(bus.SRAM_WE_N), 32'd0);
        check("wr2_dq_oe",  32'(bus.sram_dq_oe), 32'd1);
        check("wr2_dq_out", 32'(bus.sram_dq_out), 32'hBEEF);
        check("wr2_addr",   32'(bus.SRAM_ADDR), 32'h12345);
        tick();                                   // WR3
        check("wr3_we_n",   32'(bus.SRAM_WE_N), 32'd1);
        check("wr3_dq_oe",  32'(bus.sram_dq_oe), 32'd1);
        check("wr3_dq_out", 32'(bus.sram_dq_out), 32'hBEEF);
        check("wr3_addr",   32'(bus.SRAM_ADDR), 32'h12345);
        tick();                                   // IDLE
        check("wr_idle_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("wr_idle_ce_n",  32'(bus.SRAM_CE_N), 32'd1);
        check("wr_idle_busy",  32'(busy), 32'd0);

        // ---- loader read-back ----
        bus.ldr_req  = 1'b1;
        bus.ldr_we   = 1'b0;
        bus.ldr_addr = 20'h12345;
        tick();                                   // RD1
        check("rb_ack",  32'(bus.ldr_ack), 32'd1);
        check("rb_oe_n", 32'(bus.SRAM_OE_N), 32'd0);
        idle_inputs();
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.ldr_rvalid) begin
                seen = 1'b1;
                check("rb_latency", 32'(c), 32'd1);
                check("rb_rdata",   32'(bus.ldr_rdata), 32'hBEEF);
                break;
            end
        end
        check("rb_seen", 32'(seen), 32'd1);
        check("pix_rdata_hold", 32'(bus.pix_rdata), 32'h0007);
        repeat (2) tick();

        // ---- pixel streaming, 64 reads from 0x00800 ----
        for (int i = 0; i < 64; i++) exp_q.push_back(32'(16'(32'h800 + i) ^ 16'h5A5A));
        bus.pix_req  = 1'b1;
        bus.pix_addr = 20'h00800;
        acks    = 0;
        rvs     = 0;
        last_rv = -1;
        for (int c = 0; c < 300 && rvs < 64; c++) begin
            tick();
            if (bus.pix_rvalid) begin
                if (last_rv >= 0) check("stream_gap", 32'(c - last_rv), 32'd2);
                last_rv = c;
                check("stream_data", 32'(bus.pix_rdata), exp_q.pop_front());
                rvs++;
            end
            if (bus.pix_ack) begin
                acks++;
                if (acks < 64) bus.pix_addr = 20'(32'h800 + acks);
                else           bus.pix_req  = 1'b0;
            end
        end
        check("stream_count", 32'(rvs), 32'd64);
        check("stream_acks",  32'(acks), 32'd64);
        idle_inputs();
        repeat (3) tick();

        // ---- starvation: both ports request continuously ----
        bus.pix_req  = 1'b1;
        bus.pix_addr = 20'h00200;
        bus.ldr_req  = 1'b1;
        bus.ldr_we   = 1'b0;
        bus.ldr_addr = 20'h00300;
        g = 0;
        for (int c = 0; c < 300 && g < 27; c++) begin
            tick();
            if (bus.pix_ack) begin
                check("starve_grant_pix", 32'((g % 9) == 8), 32'd0);
                g++;
            end
            if (bus.ldr_ack) begin
                check("starve_grant_ldr", 32'((g % 9) == 8), 32'd1);
                g++;
            end
        end
        check("starve_grants", 32'(g), 32'd27);
        idle_inputs();
        repeat (4) tick();
        check("starve_idle_busy", 32'(busy), 32'd0);

        // ---- withdrawal: ldr_req pulsed during RD1 only ----
        bus.pix_req  = 1'b1;
        bus.pix_addr = 20'h00410;
        tick();                                   // RD1
        check("wd_pix_ack", 32'(bus.pix_ack), 32'd1);
        bus.pix_req   = 1'b0;
        bus.ldr_req   = 1'b1;
        bus.ldr_we    = 1'b1;
        bus.ldr_addr  = 20'h000FF;
        bus.ldr_wdata = 16'hDEAD;
        n_ldr_ack = 0;
        n_we_low  = 0;
        n_oe      = 0;
        seen      = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) bus.ldr_req = 1'b0;       // dropped while in RD2
            if (bus.ldr_ack)     n_ldr_ack++;
            if (!bus.SRAM_WE_N)  n_we_low++;
            if (bus.sram_dq_oe)  n_oe++;
            if (bus.pix_rvalid) begin
                seen = 1'b1;
                check("wd_pix_rdata", 32'(bus.pix_rdata), 32'h0007);
            end
        end
        check("wd_ldr_ack", 32'(n_ldr_ack), 32'd0);
        check("wd_we_low",  32'(n_we_low), 32'd0);
        check("wd_dq_oe",   32'(n_oe), 32'd0);
        check("wd_pix_rv",  32'(seen), 32'd1);
        idle_inputs();
        tick();

        // ---- reset asserted in the middle of WR2 ----
        bus.ldr_req   = 1'b1;
        bus.ldr_we    = 1'b1;
        bus.ldr_addr  = 20'h00FFF;
        bus.ldr_wdata = 16'h1234;
        tick();                                   // WR1
        idle_inputs();
        tick();                                   // WR2
        check("mid_wr2_we_n",  32'(bus.SRAM_WE_N), 32'd0);
        check("mid_wr2_dq_oe", 32'(bus.sram_dq_oe), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("async_we_n",  32'(bus.SRAM_WE_N), 32'd1);
        check("async_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        check("async_state", 32'(state_dbg), 32'(IDLE));
        tick();
        Reset_n = 1'b1;
        tick();
        check_reset_values("rst2");
        check("abandoned_write", 32'(mem[12'hFFF]), 32'h55A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
